// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage MIPS hazard/stall/forward control with data-memory wait sequencer and watchdog; define PIPECTRL_FORWARD_EN to enable forwarding
module pipeline_hazard_ctrl #(
   parameter int MAX_WAIT = 255,
   parameter int WAIT_W   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemtoRegE,
   input  logic       MemtoRegM,
   input  logic       MemWriteM,
   input  logic       BranchD,
   input  logic       PCSrcD,
   input  logic       DMemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       RegClrD,
   output logic       FlushE,
   output logic       FlushW,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       MemErr
);
   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;
   state_t            state_q, state_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic              mem_err_q, mem_err_d;
   logic              memstall, hz;
   logic [1:0]        fwd_ae, fwd_be;
   logic              fwd_ad, fwd_bd;

   function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic en);
      return en && (src != 5'd0) && (src == dst);
   endfunction

`ifdef PIPECTRL_FORWARD_EN
   // forwarding selects, plus load-use and branch-operand stalls that forwarding cannot cover
   always_comb begin
      fwd_ae = hit(RsE, WriteRegM, RegWriteM) ? 2'b10 : hit(RsE, WriteRegW, RegWriteW) ? 2'b01 : 2'b00;
      fwd_be = hit(RtE, WriteRegM, RegWriteM) ? 2'b10 : hit(RtE, WriteRegW, RegWriteW) ? 2'b01 : 2'b00;
      fwd_ad = hit(RsD, WriteRegM, RegWriteM);
      fwd_bd = hit(RtD, WriteRegM, RegWriteM);
      hz     = (MemtoRegE && (hit(RsD, RtE, 1'b1) || hit(RtD, RtE, 1'b1)))
            || (BranchD && (hit(RsD, WriteRegE, RegWriteE) || hit(RtD, WriteRegE, RegWriteE)
                         || hit(RsD, WriteRegM, MemtoRegM) || hit(RtD, WriteRegM, MemtoRegM)));
   end
`else
   logic unused_fwd_inputs;
   // no forwarding: any D-stage source still in flight in E or M stalls (W writes in the first half-cycle)
   always_comb begin
      fwd_ae = 2'b00;
      fwd_be = 2'b00;
      fwd_ad = 1'b0;
      fwd_bd = 1'b0;
      hz     = hit(RsD, WriteRegE, RegWriteE) || hit(RtD, WriteRegE, RegWriteE)
            || hit(RsD, WriteRegM, RegWriteM) || hit(RtD, WriteRegM, RegWriteM);
      unused_fwd_inputs = ^{RsE, RtE, WriteRegW, RegWriteW, MemtoRegE, BranchD};
   end
`endif

   // memory freeze overrides hazard stalls and branch clear; everything reads 0 while reset is held
   always_comb begin
      memstall  = (state_q == S_ERR) || ((MemtoRegM || MemWriteM) && !DMemReadyM);
      StallF    = !reset && (hz || memstall);
      StallD    = !reset && (hz || memstall);
      StallE    = !reset && memstall;
      StallM    = !reset && memstall;
      FlushW    = !reset && memstall;
      FlushE    = !reset && hz && !memstall;
      RegClrD   = !reset && PCSrcD && !hz && !memstall;
      ForwardAE = reset ? 2'b00 : fwd_ae;
      ForwardBE = reset ? 2'b00 : fwd_be;
      ForwardAD = !reset && fwd_ad;
      ForwardBD = !reset && fwd_bd;
      MemErr    = mem_err_q;
   end

   // wait sequencer: enter WAIT on a stalled access, count wait cycles, trip the watchdog at MAX_WAIT
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      case (state_q)
         S_RUN: begin
            if (memstall) begin
               state_d = S_WAIT;
               cnt_d   = WAIT_W'(1);
            end
         end
         S_WAIT: begin
            if (DMemReadyM) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else if (cnt_q == WAIT_W'(MAX_WAIT)) begin
               state_d   = S_ERR;
               mem_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ERR: state_d = S_ERR;
         default: state_d = S_RUN;
      endcase
   end

   // wait-state register, cycle counter and sticky watchdog flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_RUN;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end
endmodule
